// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cache_refill_ctrl : single-entry MSHR - victim writeback, refill, tag/LRU  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module cache_refill_ctrl #(
    parameter int TAG_W  = 28,
    parameter int IDX_W  = 6,
    parameter int DATA_W = 64,
    parameter int BEATS  = 8,
    parameter int WAY_W  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss_valid,
    output logic                         miss_ready,
    input  logic [TAG_W-1:0]             miss_tag,
    input  logic [IDX_W-1:0]             miss_index,
    input  logic [WAY_W-1:0]             miss_way,
    input  logic                         victim_valid,
    input  logic                         victim_dirty,
    input  logic [TAG_W-1:0]             victim_tag,
    output logic                         mshr_valid,
    output logic                         mshr_rw,
    output logic [IDX_W-1:0]             mshr_bank_index,
    output logic [TAG_W-1:0]             mshr_new_tag,
    output logic [WAY_W-1:0]             mshr_way_id,
    output logic                         dram_rd_en,
    output logic [$clog2(BEATS)-1:0]     dram_rd_beat,
    input  logic [DATA_W-1:0]            dram_rd_data,
    output logic                         fill_we,
    output logic [$clog2(BEATS)-1:0]     fill_beat,
    output logic [DATA_W-1:0]            fill_data,
    output logic                         tag_we,
    output logic                         lru_upd,
    output logic                         aw_valid,
    input  logic                         aw_ready,
    output logic [TAG_W+IDX_W+5:0]       aw_addr,
    output logic                         w_valid,
    input  logic                         w_ready,
    output logic [DATA_W-1:0]            w_data,
    output logic                         w_last,
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic                         b_err,
    output logic                         ar_valid,
    input  logic                         ar_ready,
    output logic [TAG_W+IDX_W+5:0]       ar_addr,
    input  logic                         r_valid,
    output logic                         r_ready,
    input  logic [DATA_W-1:0]            r_data,
    input  logic                         r_last,
    input  logic                         r_err,
    output logic                         done,
    output logic                         done_err
);

    localparam int                BEAT_W    = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WB_AW = 3'd1,
        S_WB_W  = 3'd2,
        S_WB_B  = 3'd3,
        S_RD_AR = 3'd4,
        S_RD_R  = 3'd5,
        S_FILL  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic                mshr_valid_q, mshr_valid_d;
    logic                mshr_rw_q, mshr_rw_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [TAG_W-1:0]    new_tag_q, new_tag_d;
    logic [WAY_W-1:0]    way_q, way_d;
    logic [TAG_W-1:0]    victim_tag_q, victim_tag_d;
    logic                err_q, err_d;
    logic [BEAT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic                rd_all_q, rd_all_d;
    logic                rd_inflight_q, rd_inflight_d;
    logic                buf_full_q, buf_full_d;
    logic [DATA_W-1:0]   buf_data_q, buf_data_d;
    logic [BEAT_W-1:0]   w_cnt_q, w_cnt_d;
    logic [BEAT_W-1:0]   r_cnt_q, r_cnt_d;
    logic                rd_issue;

    // Only one victim read may be outstanding and only into an empty buffer.
    assign rd_issue = (state_q == S_WB_W) && !buf_full_q && !rd_inflight_q && !rd_all_q;

    always_comb begin
        state_d       = state_q;
        mshr_valid_d  = mshr_valid_q;
        mshr_rw_d     = mshr_rw_q;
        index_d       = index_q;
        new_tag_d     = new_tag_q;
        way_d         = way_q;
        victim_tag_d  = victim_tag_q;
        err_d         = err_q;
        rd_cnt_d      = rd_cnt_q;
        rd_all_d      = rd_all_q;
        rd_inflight_d = rd_inflight_q;
        buf_full_d    = buf_full_q;
        buf_data_d    = buf_data_q;
        w_cnt_d       = w_cnt_q;
        r_cnt_d       = r_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (miss_valid) begin
                    index_d      = miss_index;
                    new_tag_d    = miss_tag;
                    way_d        = miss_way;
                    victim_tag_d = victim_tag;
                    mshr_valid_d = 1'b1;
                    err_d        = 1'b0;
                    rd_cnt_d     = '0;
                    rd_all_d     = 1'b0;
                    w_cnt_d      = '0;
                    if (victim_valid && victim_dirty) begin
                        mshr_rw_d = 1'b1;
                        state_d   = S_WB_AW;
                    end else begin
                        state_d   = S_RD_AR;
                    end
                end
            end
            S_WB_AW: begin
                if (aw_ready) state_d = S_WB_W;
            end
            S_WB_W: begin
                if (rd_issue) begin
                    rd_inflight_d = 1'b1;
                    rd_cnt_d      = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST_BEAT) rd_all_d = 1'b1;
                end
                if (rd_inflight_q) begin
                    rd_inflight_d = 1'b0;
                    buf_full_d    = 1'b1;
                    buf_data_d    = dram_rd_data;
                end
                if (buf_full_q && w_ready) begin
                    buf_full_d = 1'b0;
                    w_cnt_d    = w_cnt_q + 1'b1;
                    if (w_cnt_q == LAST_BEAT) state_d = S_WB_B;
                end
            end
            S_WB_B: begin
                if (b_valid) begin
                    err_d     = err_q | b_err;
                    mshr_rw_d = 1'b0;
                    state_d   = S_RD_AR;
                end
            end
            S_RD_AR: begin
                if (ar_ready) begin
                    r_cnt_d = '0;
                    state_d = S_RD_R;
                end
            end
            S_RD_R: begin
                if (r_valid) begin
                    r_cnt_d = r_cnt_q + 1'b1;
                    // The beat counter decides burst end; r_last is only cross-checked.
                    if (r_err || (r_last != (r_cnt_q == LAST_BEAT))) err_d = 1'b1;
                    if (r_cnt_q == LAST_BEAT) state_d = S_FILL;
                end
            end
            S_FILL: state_d = S_DONE;
            S_DONE: begin
                mshr_valid_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mshr_valid_q  <= 1'b0;
            mshr_rw_q     <= 1'b0;
            index_q       <= '0;
            new_tag_q     <= '0;
            way_q         <= '0;
            victim_tag_q  <= '0;
            err_q         <= 1'b0;
            rd_cnt_q      <= '0;
            rd_all_q      <= 1'b0;
            rd_inflight_q <= 1'b0;
            buf_full_q    <= 1'b0;
            buf_data_q    <= '0;
            w_cnt_q       <= '0;
            r_cnt_q       <= '0;
        end else begin
            state_q       <= state_d;
            mshr_valid_q  <= mshr_valid_d;
            mshr_rw_q     <= mshr_rw_d;
            index_q       <= index_d;
            new_tag_q     <= new_tag_d;
            way_q         <= way_d;
            victim_tag_q  <= victim_tag_d;
            err_q         <= err_d;
            rd_cnt_q      <= rd_cnt_d;
            rd_all_q      <= rd_all_d;
            rd_inflight_q <= rd_inflight_d;
            buf_full_q    <= buf_full_d;
            buf_data_q    <= buf_data_d;
            w_cnt_q       <= w_cnt_d;
            r_cnt_q       <= r_cnt_d;
        end
    end

    assign miss_ready      = (state_q == S_IDLE);
    assign mshr_valid      = mshr_valid_q;
    assign mshr_rw         = mshr_rw_q;
    assign mshr_bank_index = index_q;
    assign mshr_new_tag    = new_tag_q;
    assign mshr_way_id     = way_q;
    assign dram_rd_en      = rd_issue;
    assign dram_rd_beat    = rd_cnt_q;
    assign aw_valid        = (state_q == S_WB_AW);
    assign aw_addr         = {victim_tag_q, index_q, 6'b0};
    assign w_valid         = (state_q == S_WB_W) && buf_full_q;
    assign w_data          = buf_data_q;
    assign w_last          = w_valid && (w_cnt_q == LAST_BEAT);
    assign b_ready         = (state_q == S_WB_B);
    assign ar_valid        = (state_q == S_RD_AR);
    assign ar_addr         = {new_tag_q, index_q, 6'b0};
    assign r_ready         = (state_q == S_RD_R);
    assign fill_we         = (state_q == S_RD_R) && r_valid;
    assign fill_beat       = r_cnt_q;
    assign fill_data       = r_data;
    assign tag_we          = (state_q == S_FILL);
    assign lru_upd         = (state_q == S_FILL);
    assign done            = (state_q == S_DONE);
    assign done_err        = (state_q == S_DONE) && err_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// Bench for cache_refill_ctrl: one miss at a time against a transaction-level model
// of the victim line, the AXI slave and the expected fill/tag/done sequence.
module tb_cache_refill_ctrl;

    logic        clk;
    logic        rst;
    logic        miss_valid, miss_ready;
    logic [27:0] miss_tag;
    logic [5:0]  miss_index;
    logic [2:0]  miss_way;
    logic        victim_valid, victim_dirty;
    logic [27:0] victim_tag;
    logic        mshr_valid, mshr_rw;
    logic [5:0]  mshr_bank_index;
    logic [27:0] mshr_new_tag;
    logic [2:0]  mshr_way_id;
    logic        dram_rd_en;
    logic [2:0]  dram_rd_beat;
    logic [63:0] dram_rd_data;
    logic        fill_we;
    logic [2:0]  fill_beat;
    logic [63:0] fill_data;
    logic        tag_we, lru_upd;
    logic        aw_valid, aw_ready;
    logic [39:0] aw_addr;
    logic        w_valid, w_ready, w_last;
    logic [63:0] w_data;
    logic        b_valid, b_ready, b_err;
    logic        ar_valid, ar_ready;
    logic [39:0] ar_addr;
    logic        r_valid, r_ready, r_last, r_err;
    logic [63:0] r_data;
    logic        done, done_err;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [5:0]  prev_idx = '0;
    logic [27:0] nx_tag, nx_vtag;
    logic [5:0]  nx_idx;
    logic [2:0]  nx_way;

    cache_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_tag(miss_tag), .miss_index(miss_index), .miss_way(miss_way),
        .victim_valid(victim_valid), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .mshr_valid(mshr_valid), .mshr_rw(mshr_rw), .mshr_bank_index(mshr_bank_index),
        .mshr_new_tag(mshr_new_tag), .mshr_way_id(mshr_way_id),
        .dram_rd_en(dram_rd_en), .dram_rd_beat(dram_rd_beat), .dram_rd_data(dram_rd_data),
        .fill_we(fill_we), .fill_beat(fill_beat), .fill_data(fill_data),
        .tag_we(tag_we), .lru_upd(lru_upd),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_err(b_err),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last), .r_err(r_err),
        .done(done), .done_err(done_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_miss_ready"}, 64'(miss_ready), 64'd1);
        chk({tag, "_mshr_valid"}, 64'(mshr_valid), 64'd0);
        chk({tag, "_mshr_rw"},    64'(mshr_rw), 64'd0);
        chk({tag, "_mshr_fields"}, 64'({mshr_bank_index, mshr_new_tag, mshr_way_id}), 64'd0);
        chk({tag, "_enables"}, 64'({fill_we, tag_we, lru_upd, dram_rd_en, done, done_err}), 64'd0);
        chk({tag, "_bus"}, 64'({aw_valid, w_valid, b_ready, ar_valid, r_ready}), 64'd0);
    endtask

    // Runs one miss from the accept cycle to its done pulse, acting as the
    // victim data RAM and the AXI slave. Called and returning on a negedge.
    task automatic do_miss(input logic [27:0] tag, input logic [5:0] idx, input logic [2:0] way,
                           input logic vv, input logic vd, input logic [27:0] vtag,
                           input int wmode, input bit rnd, input logic berr,
                           input int last_at, input int rerr_beat, input int rst_beat,
                           input bit hold, input bit tchk);
        logic [63:0] vline [8];
        logic [63:0] rline [8];
        int  cyc = 0, wb = 0, rb = 0, fb = 0, rdreq = 0, tagwe_n = 0, aw_n = 0, pend = -1;
        bit  aw_done = 0, b_done = 0, ar_done = 0, finished = 0, aborted = 0;
        bit  dirty = vv && vd;
        bit  exp_err;
        for (int i = 0; i < 8; i++) begin
            vline[i] = {$urandom, $urandom};
            rline[i] = {$urandom, $urandom};
        end
        exp_err = (dirty && berr) || (rerr_beat >= 0 && rerr_beat < 8) || (last_at != 7);
        while (!finished && cyc < 400) begin
            if (cyc == 0) begin
                miss_valid = 1'b1; miss_tag = tag; miss_index = idx; miss_way = way;
                victim_valid = vv; victim_dirty = vd; victim_tag = vtag;
            end else if (hold) begin
                miss_valid = 1'b1; miss_tag = nx_tag; miss_index = nx_idx; miss_way = nx_way;
                victim_valid = 1'b1; victim_dirty = 1'b1; victim_tag = nx_vtag;
            end else begin
                miss_valid = 1'b0; miss_tag = 28'($urandom); miss_index = 6'($urandom);
                miss_way = 3'($urandom); victim_valid = 1'($urandom);
                victim_dirty = 1'($urandom); victim_tag = 28'($urandom);
            end
            dram_rd_data = (pend >= 0) ? vline[pend] : {$urandom, $urandom};
            pend     = -1;
            aw_ready = rnd ? 1'($urandom) : 1'b1;
            w_ready  = (wmode == 0) ? 1'b1 : (wmode == 1) ? 1'(cyc % 2) : 1'($urandom);
            b_valid  = (wb == 8) && !b_done && (rnd ? 1'($urandom) : 1'b1);
            b_err    = berr;
            ar_ready = rnd ? 1'($urandom) : 1'b1;
            r_valid  = ar_done && (rb < 8) && (rnd ? 1'($urandom) : 1'b1);
            r_data   = r_valid ? rline[rb] : {$urandom, $urandom};
            r_last   = r_valid && (rb == last_at);
            r_err    = r_valid && (rb == rerr_beat);
            if (rst_beat >= 0 && r_valid && rb == rst_beat) begin
                rst = 1'b1;
                #1;
                chk_idle_outputs("async_rst");
                @(negedge clk);
                rst = 1'b0; miss_valid = 1'b0;
                for (int k = 0; k < 12; k++) begin
                    r_valid = 1'b1;
                    #1;
                    chk("post_rst_no_write", 64'({fill_we, tag_we, mshr_valid}), 64'd0);
                    chk("post_rst_ready", 64'(miss_ready), 64'd1);
                    @(negedge clk);
                end
                r_valid = 1'b0; r_last = 1'b0; r_err = 1'b0;
                prev_idx = '0;
                aborted  = 1;
                break;
            end
            #1;
            chk("miss_ready", 64'(miss_ready), 64'(cyc == 0));
            chk("mshr_valid", 64'(mshr_valid), 64'(cyc != 0));
            chk("mshr_index", 64'(mshr_bank_index), 64'((cyc == 0) ? prev_idx : idx));
            chk("mshr_rw", 64'(mshr_rw), 64'(cyc != 0 && dirty && !b_done));
            if (dram_rd_en) begin
                chk("rd_beat", 64'(dram_rd_beat), 64'(rdreq % 8));
                chk("rd_in_range", 64'(rdreq < 8), 64'd1);
                pend = rdreq % 8;
                rdreq++;
            end
            if (aw_valid && aw_ready) begin
                chk("aw_addr", 64'(aw_addr), 64'({vtag, idx, 6'b0}));
                aw_n++;
                aw_done = 1;
            end
            if (w_valid && w_ready) begin
                chk("w_data", w_data, vline[wb % 8]);
                chk("w_last", 64'(w_last), 64'(wb == 7));
                chk("w_after_aw", 64'(aw_done), 64'd1);
                wb++;
            end
            if (b_valid && b_ready) b_done = 1;
            if (ar_valid && ar_ready) begin
                chk("ar_addr", 64'(ar_addr), 64'({tag, idx, 6'b0}));
                chk("wb_before_rd", 64'(b_done), 64'(dirty));
                if (tchk) chk("ar_cycle", 64'(cyc), 64'd1);
                ar_done = 1;
            end
            if (r_valid) begin
                chk("r_ready", 64'(r_ready), 64'd1);
                chk("fill_we", 64'(fill_we), 64'd1);
                rb++;
            end
            if (fill_we) begin
                chk("fill_beat", 64'(fill_beat), 64'(fb % 8));
                chk("fill_data", fill_data, rline[fb % 8]);
                chk("fill_way", 64'(mshr_way_id), 64'(way));
                fb++;
            end
            if (tag_we) begin
                chk("tag_fields", 64'({mshr_new_tag, mshr_bank_index, mshr_way_id}),
                    64'({tag, idx, way}));
                chk("lru_upd", 64'(lru_upd), 64'd1);
                chk("fills_before_tag", 64'(fb), 64'd8);
                if (tchk) chk("tag_cycle", 64'(cyc), 64'd10);
                tagwe_n++;
            end
            if (done) begin
                chk("done_err", 64'(done_err), 64'(exp_err));
                chk("tag_we_count", 64'(tagwe_n), 64'd1);
                chk("aw_count", 64'(aw_n), 64'(dirty));
                chk("w_count", 64'(wb), dirty ? 64'd8 : 64'd0);
                if (tchk) chk("done_cycle", 64'(cyc), 64'd11);
                if (dirty) chk("dirty_min_latency", 64'(cyc >= 29), 64'd1);
                finished = 1;
            end
            @(negedge clk);
            cyc++;
        end
        if (!aborted) begin
            chk("miss_completed", 64'(finished), 64'd1);
            prev_idx = idx;
        end
    endtask

    initial begin
        rst = 1'b1;
        miss_valid = 0; miss_tag = '0; miss_index = '0; miss_way = '0;
        victim_valid = 0; victim_dirty = 0; victim_tag = '0; dram_rd_data = '0;
        aw_ready = 0; w_ready = 0; b_valid = 0; b_err = 0; ar_ready = 0;
        r_valid = 0; r_data = '0; r_last = 0; r_err = 0;
        @(negedge clk);
        chk_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Clean miss on a zero-wait bus, cycle-exact.
        do_miss(28'h1234, 6'd5, 3'd2, 1'b0, 1'b0, 28'h0, 0, 0, 1'b0, 7, -1, -1, 0, 1);
        // Dirty miss with w_ready toggling.
        do_miss(28'h0777, 6'd9, 3'd4, 1'b1, 1'b1, 28'hABC, 1, 0, 1'b0, 7, -1, -1, 0, 0);
        // Writeback error, clean refill.
        do_miss(28'h0321, 6'd17, 3'd1, 1'b1, 1'b1, 28'h0BEEF, 0, 0, 1'b1, 7, -1, -1, 0, 0);
        // Early r_last on beat 5.
        do_miss(28'h5555, 6'd33, 3'd6, 1'b0, 1'b1, 28'h0, 0, 0, 1'b0, 5, -1, -1, 0, 0);
        // Read error on beat 2.
        do_miss(28'h0AAA, 6'd40, 3'd3, 1'b1, 1'b0, 28'h0, 0, 0, 1'b0, 7, 2, -1, 0, 0);
        // Back-to-back with miss_valid held high.
        nx_tag = 28'h0FACE; nx_idx = 6'd62; nx_way = 3'd7; nx_vtag = 28'h0D00D;
        do_miss(28'h0123, 6'd11, 3'd5, 1'b0, 1'b0, 28'h0, 0, 0, 1'b0, 7, -1, -1, 1, 0);
        do_miss(nx_tag, nx_idx, nx_way, 1'b1, 1'b1, nx_vtag, 0, 0, 1'b0, 7, -1, -1, 0, 0);
        // Reset while streaming beat 3, then a normal miss.
        do_miss(28'h0BAD, 6'd21, 3'd2, 1'b0, 1'b0, 28'h0, 0, 0, 1'b0, 7, -1, 3, 0, 0);
        do_miss(28'h1234, 6'd5, 3'd2, 1'b0, 1'b0, 28'h0, 0, 0, 1'b0, 7, -1, -1, 0, 1);

        for (int n = 0; n < 24; n++) begin
            do_miss(28'($urandom), 6'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                    28'($urandom), 2, 1, 1'(($urandom % 4) == 0),
                    (($urandom % 4) == 0) ? int'($urandom % 8) : 7,
                    (($urandom % 5) == 0) ? int'($urandom % 8) : -1, -1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
